irq_dispatch: RTL and testbench

//  Interrupt sequencer directly downstream of the interrupt priority encoder.

---
 rtl/irq_dispatch_if.sv | 30 +++
 rtl/irq_dispatch.sv | 99 +++++++++
 tb/tb_irq_dispatch.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/irq_dispatch_if.sv
// Bundle between the priority encoder / core and the interrupt dispatcher.
// The slave modport is the dispatcher; the master modport is its environment.
interface irq_dispatch_if #(
   parameter int unsigned NUM_VECTORS = 4,
   parameter int unsigned PC_WIDTH    = 16
);
   localparam int unsigned NVL2 = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;

   logic                   iflag;
   logic [NVL2-1:0]        ivect;
   logic                   gie;
   logic                   insn_boundary;
   logic                   irq_ack;
   logic                   reti;
   logic                   irq_req;
   logic [PC_WIDTH-1:0]    irq_addr;
   logic [NUM_VECTORS-1:0] irq_clear;
   logic                   in_service;
   logic [NVL2-1:0]        active_vect;

   modport slave (
      input  iflag, ivect, gie, insn_boundary, irq_ack, reti,
      output irq_req, irq_addr, irq_clear, in_service, active_vect
   );

   modport master (
      output iflag, ivect, gie, insn_boundary, irq_ack, reti,
      input  irq_req, irq_addr, irq_clear, in_service, active_vect
   );
endinterface

// File: rtl/irq_dispatch.sv
// Interrupt sequencer: qualifies encoder requests with SREG I and instruction
// boundaries, handshakes with the core, pulses the source clear, blocks nesting.
module irq_dispatch #(
   parameter int unsigned          NUM_VECTORS = 4,
   parameter int unsigned          PC_WIDTH    = 16,
   parameter logic [PC_WIDTH-1:0]  VEC_BASE    = 16'h0002,
   parameter int unsigned          VEC_STRIDE  = 2
) (
   input logic           clk,
   input logic           rst,
   irq_dispatch_if.slave bus
);
   localparam int unsigned NVL2 = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StService
   } state_e;

   state_e                 r_state, w_state_next;
   logic                   r_irq_req, w_irq_req_next;
   logic [PC_WIDTH-1:0]    r_irq_addr, w_irq_addr_next;
   logic [NUM_VECTORS-1:0] r_irq_clear, w_irq_clear_next;
   logic                   r_in_service, w_in_service_next;
   logic [NVL2-1:0]        r_active_vect, w_active_vect_next;
   logic [PC_WIDTH-1:0]    w_vec_addr;
   logic                   w_qualified;

   assign w_qualified = bus.iflag & bus.gie & bus.insn_boundary;
   // Modulo-2^PC_WIDTH arithmetic: vector table wraps rather than saturating.
   assign w_vec_addr  = VEC_BASE + (PC_WIDTH'(bus.ivect) * PC_WIDTH'(VEC_STRIDE));

   always_comb begin
      w_state_next       = r_state;
      w_irq_req_next     = r_irq_req;
      w_irq_addr_next    = r_irq_addr;
      w_irq_clear_next   = '0;
      w_in_service_next  = r_in_service;
      w_active_vect_next = r_active_vect;
      unique case (r_state)
         StIdle: begin
            if (w_qualified) begin
               w_state_next       = StReq;
               w_irq_req_next     = 1'b1;
               w_irq_addr_next    = w_vec_addr;
               w_active_vect_next = bus.ivect;
            end
         end
         StReq: begin
            // Ack takes precedence over a simultaneous drop of I.
            if (bus.irq_ack) begin
               w_state_next      = StService;
               w_irq_req_next    = 1'b0;
               w_in_service_next = 1'b1;
               w_irq_clear_next  = NUM_VECTORS'(1) << r_active_vect;
            end else if (!bus.gie) begin
               w_state_next   = StIdle;
               w_irq_req_next = 1'b0;
            end
         end
         StService: begin
            if (bus.reti) begin
               w_state_next      = StIdle;
               w_in_service_next = 1'b0;
            end
         end
         default: begin
            w_state_next      = StIdle;
            w_irq_req_next    = 1'b0;
            w_in_service_next = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= StIdle;
         r_irq_req     <= 1'b0;
         r_irq_addr    <= '0;
         r_irq_clear   <= '0;
         r_in_service  <= 1'b0;
         r_active_vect <= '0;
      end else begin
         r_state       <= w_state_next;
         r_irq_req     <= w_irq_req_next;
         r_irq_addr    <= w_irq_addr_next;
         r_irq_clear   <= w_irq_clear_next;
         r_in_service  <= w_in_service_next;
         r_active_vect <= w_active_vect_next;
      end
   end

   assign bus.irq_req     = r_irq_req;
   assign bus.irq_addr    = r_irq_addr;
   assign bus.irq_clear   = r_irq_clear;
   assign bus.in_service  = r_in_service;
   assign bus.active_vect = r_active_vect;
endmodule

// File: tb/tb_irq_dispatch.sv
// Self-checking bench for irq_dispatch: directed scenarios then random traffic,
// all checked against a transaction-level reference model.
module tb_irq_dispatch;
   localparam int unsigned NV     = 4;
   localparam int unsigned PW     = 16;
   localparam logic [15:0] BASE   = 16'h0002;
   localparam int unsigned STRIDE = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   irq_dispatch_if #(.NUM_VECTORS(NV), .PC_WIDTH(PW)) bus ();

   irq_dispatch #(
      .NUM_VECTORS(NV),
      .PC_WIDTH   (PW),
      .VEC_BASE   (BASE),
      .VEC_STRIDE (STRIDE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: a request is outstanding, or a handler is running, or neither.
   bit          m_pending;
   bit          m_serving;
   int unsigned m_vect;
   int unsigned m_addr;
   int unsigned m_clear;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pending = 0;
      m_serving = 0;
      m_vect    = 0;
      m_addr    = 0;
      m_clear   = 0;
   endtask

   task automatic model_step();
      m_clear = 0;
      if (m_pending) begin
         if (bus.irq_ack) begin
            m_pending = 0;
            m_serving = 1;
            m_clear   = 1 << m_vect;
         end else if (!bus.gie) begin
            m_pending = 0;
         end
      end else if (m_serving) begin
         if (bus.reti) m_serving = 0;
      end else if (bus.iflag && bus.gie && bus.insn_boundary) begin
         m_pending = 1;
         m_vect    = bus.ivect;
         m_addr    = (BASE + m_vect * STRIDE) % 65536;
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".irq_req"},     32'(bus.irq_req),     32'(m_pending));
      chk({tag, ".irq_addr"},    32'(bus.irq_addr),    m_addr);
      chk({tag, ".irq_clear"},   32'(bus.irq_clear),   m_clear);
      chk({tag, ".in_service"},  32'(bus.in_service),  32'(m_serving));
      chk({tag, ".active_vect"}, 32'(bus.active_vect), m_vect);
   endtask

   task automatic drive(input bit f, input int unsigned v, input bit g, input bit b,
                        input bit a, input bit r);
      bus.iflag         = f;
      bus.ivect         = 2'(v);
      bus.gie           = g;
      bus.insn_boundary = b;
      bus.irq_ack       = a;
      bus.reti          = r;
   endtask

   // Inputs change at the negedge; model and DUT both sample at the posedge.
   task automatic tick(input string tag);
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
      @(negedge clk);
      check_model(tag);
   endtask

   task automatic async_reset(input string tag);
      #1 rst = 1'b1;
      #1 model_reset();
      check_model(tag);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0);
      model_reset();
      #1 check_model("reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      tick("idle");

      // Basic request/ack/reti on vector 2.
      drive(1, 2, 1, 1, 0, 0);
      tick("basic.req");
      chk("basic.addr_const", 32'(bus.irq_addr), 32'h0006);
      drive(0, 2, 1, 0, 0, 0);
      tick("basic.hold");
      drive(0, 2, 1, 0, 1, 0);
      tick("basic.ack");
      chk("basic.clear_const", 32'(bus.irq_clear), 32'b0100);
      drive(0, 0, 1, 0, 0, 0);
      tick("basic.clear_gone");
      drive(0, 0, 1, 0, 0, 1);
      tick("basic.reti");
      drive(0, 0, 1, 0, 0, 0);
      tick("basic.idle");

      // Gating: gie low, then boundary low.
      drive(1, 1, 0, 1, 0, 0);
      repeat (20) tick("gate.gie");
      drive(1, 1, 1, 0, 0, 0);
      repeat (20) tick("gate.boundary");
      chk("gate.no_req", 32'(bus.irq_req), 32'd0);

      // Abort by dropping gie while requesting.
      drive(1, 1, 1, 1, 0, 0);
      tick("abort.req");
      drive(1, 3, 0, 1, 0, 0);
      tick("abort.drop");
      chk("abort.req_low", 32'(bus.irq_req), 32'd0);
      repeat (3) tick("abort.quiet");

      // Ack together with gie=0: ack wins.
      drive(1, 3, 1, 1, 0, 0);
      tick("ackwin.req");
      drive(0, 0, 0, 0, 1, 0);
      tick("ackwin.ack");
      chk("ackwin.clear_const", 32'(bus.irq_clear), 32'b1000);
      drive(0, 0, 0, 0, 0, 1);
      tick("ackwin.reti");

      // No nesting while in service; next request two cycles after reti.
      drive(1, 1, 1, 1, 0, 0);
      tick("nest.req");
      drive(1, 1, 1, 1, 1, 0);
      tick("nest.ack");
      drive(1, 0, 1, 1, 0, 0);
      repeat (5) tick("nest.blocked");
      drive(1, 0, 1, 1, 0, 1);
      tick("nest.reti");
      chk("nest.k1_no_req", 32'(bus.irq_req), 32'd0);
      drive(1, 0, 1, 1, 0, 0);
      tick("nest.k2");
      chk("nest.k2_req", 32'(bus.irq_req), 32'd1);
      chk("nest.k2_addr", 32'(bus.irq_addr), 32'h0002);

      // Async reset mid-REQ with ack pending: clear must not appear.
      drive(0, 0, 1, 0, 1, 0);
      async_reset("rst.req");
      tick("rst.req_after");
      // Async reset mid-SERVICE.
      drive(1, 2, 1, 1, 0, 0);
      tick("rst.svc_req");
      drive(0, 0, 1, 0, 1, 0);
      tick("rst.svc_ack");
      drive(0, 0, 1, 0, 0, 0);
      async_reset("rst.svc");
      tick("rst.svc_after");

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         drive(1'($urandom_range(0, 1)), $urandom_range(0, NV - 1),
               $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
               $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
         tick("rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
